csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
- Drives the trap-set and privilege-set side of the CSR register file.
- Accepts synchronous exception, MRET and SRET requests from the pipeline. Computes delegation, new status bits, cause and EPC values, and the new privilege level.
- Commits them in one trap-set pulse, then issues a PC redirect and flush to the fetch stage.
- Handles synchronous exceptions only. Interrupt entry and mideleg are out of scope.

Parameters:
- SUPPORT_S, 1: supervisor mode implemented. When 0: no delegation, and SRET is illegal.
- SUPPORT_U, 1: user mode implemented. Selects the MPP value written on MRET: U when 1, M when 0.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- excValid_i  in  1  exception request
- excCause_i  in  5  exception code
- instPC_i  in  32  PC of the faulting / xRET instruction
- mretValid_i  in  1  MRET retiring
- sretValid_i  in  1  SRET retiring
- csrMStatus_i  in  64  {mstatush, mstatus} from the CSR file
- csrMedeleg_i  in  64  medeleg
- csrMtvec_i  in  32  mtvec
- csrStvec_i  in  32  stvec
- csrMepc_i  in  32  mepc
- csrSepc_i  in  32  sepc
- csrMCause_i  in  32  mcause
- csrSCause_i  in  32  scause
- privilege_i  in  2  current privilege
- csrMStatusSet_o  out  7  {MPP[1:0], MPIE, MIE, SPP, SPIE, SIE}
- csrMepcSet_o  out  32  mepc value for the trap-set write
- csrMCauseSet_o  out  32  mcause value for the trap-set write
- csrSepcSet_o  out  32  sepc value for the trap-set write
- csrSCauseSet_o  out  32  scause value for the trap-set write
- csrTrapSetEn_o  out  1  one-cycle trap-set write strobe
- privilegeSet_o  out  2  new privilege level
- privilegeSetEn_o  out  1  one-cycle privilege write strobe
- flush_o  out  1  pipeline flush
- redirectValid_o  out  1  PC redirect strobe
- redirectPC_o  out  32  redirect target
- busy_o  out  1  stall request

Behaviour:
- Clock and reset: single clock clk_i. Synchronous, active-high reset reset_i.
- FSM states:
  - IDLE: waits for a request.
  - COMMIT: one cycle.
  - REDIRECT: one cycle, then returns to IDLE.
- Acceptance: in IDLE, any valid request is latched at the clock edge and the FSM enters COMMIT. At the edge of accept, the unit snapshots instPC, cause, kind, privilege_i and all CSR inputs. Later CSR changes do not affect the operation in flight.
- Request priority when simultaneous: exception, then MRET, then SRET.
- Busy and ignored requests: busy_o=1 in COMMIT and REDIRECT. Requests arriving in those states are ignored; the pipeline must hold them.
- Illegal xRET: converted at accept into exception cause 2 (illegal instruction) in these cases:
  - MRET with privilege != M;
  - SRET with privilege == U;
  - SRET in S with mstatus.TSR (bit 22) = 1;
  - SRET when SUPPORT_S = 0.
- Exception target: S when SUPPORT_S=1, snapshot privilege != M, and medeleg[cause]=1. Otherwise the target is M.
- Trap to M:
  - MPP = old privilege; MPIE = MIE; MIE = 0.
  - mepc = {instPC[31:1], 0}; mcause = {27'b0, cause}.
  - New privilege 11. Redirect to {mtvec[31:2], 00}.
- Trap to S:
  - SPP = old privilege[0]; SPIE = SIE; SIE = 0.
  - sepc and scause are set as for M.
  - New privilege 01. Redirect to {stvec[31:2], 00}.
- MRET:
  - New privilege = MPP; MIE = MPIE; MPIE = 1.
  - MPP = 00 if SUPPORT_U, else 11.
  - Redirect to mepc.
- SRET:
  - New privilege = {0, SPP}; SIE = SPIE; SPIE = 1; SPP = 0.
  - Redirect to sepc.
- Pass-through: every set output field not modified by the operation is driven with the snapshotted current value, so the single csrTrapSetEn write is lossless. This includes the untouched EPC/cause pair and the untouched status bits.
- Vectored tvec mode: irrelevant, because exceptions always use the base address.
- COMMIT outputs: csrTrapSetEn_o = 1, privilegeSetEn_o = 1, flush_o = 1. For MRET and SRET, csrTrapSetEn_o still pulses to update the status bits, with EPC and cause passed through.
- REDIRECT outputs: redirectValid_o = 1 and redirectPC_o valid. flush_o stays 1.
- Latency: accept edge N. CSR and privilege write at edge N+1. Redirect visible during cycle N+2.
- Reset values: all strobes 0, all data outputs 0, busy_o = 0, state IDLE.
- Reset mid-operation: the FSM returns to IDLE and all strobes go to 0. A trap whose COMMIT cycle coincides with reset is not applied, because the CSR file also resets.

Decomposition:
- Package riscv_priv_pkg:
  - privilege encodings (U=00, S=01, M=11);
  - mstatus bit positions (SIE 1, MIE 3, SPIE 5, MPIE 7, SPP 8, MPP 12:11, TSR 22);
  - cause codes (ILLEGAL_INST 2, ECALL_U 8, ECALL_S 9, ECALL_M 11);
  - FSM state enum;
  - request-kind enum.
- Sub-module trap_status_calc: combinational logic for delegation, the new 7-bit status, new privilege and target PC from the snapshot. The FSM, snapshot registers and strobes remain in csr_trap_unit.

Test Plan:
- ECALL from U, delegation to S. privilege 00, medeleg[8]=1, stvec=0x8000_0101, pc=0x0000_1234, cause 8:
  - edge N+1: SPP=0, SPIE=old SIE, sepc=0x1234, scause=8, privilege 01;
  - cycle N+2: redirectPC=0x8000_0100.
- Same request with medeleg=0, mtvec=0x100, MIE=1:
  - MPP=00, MPIE=1, MIE=0, mepc=0x1234, mcause=8, privilege 11;
  - redirect 0x100;
  - sepc/scause unchanged.
- MRET from M with MPP=01, MPIE=1, mepc=0x2000:
  - privilege 01, MIE=1, MPIE=1, MPP=00;
  - redirect 0x2000.
- Illegal xRET:
  - MRET from S, pc=0x40, mtvec=0x200: mcause=2, mepc=0x40, privilege 11, redirect 0x200;
  - SRET from S with TSR=1: same handling, cause 2.
- Simultaneous requests and busy: excValid and mretValid in the same cycle:
  - the exception wins;
  - a new excValid during COMMIT is ignored;
  - busy_o=1 for exactly 2 cycles.
- Reset mid-operation: assert reset_i during COMMIT:
  - the next cycle has all strobes 0 and the FSM in IDLE;
  - no redirect is issued.

Source files
------------

// File: rtl/riscv_priv_pkg.sv
// Privilege-level encodings, mstatus layout and trap-unit types
// shared by the CSR trap/return sequencer.
package riscv_priv_pkg;

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;

   localparam int MST_SIE  = 1;
   localparam int MST_MIE  = 3;
   localparam int MST_SPIE = 5;
   localparam int MST_MPIE = 7;
   localparam int MST_SPP  = 8;
   localparam int MST_MPP  = 11;
   localparam int MST_TSR  = 22;

   // Bit positions inside the packed 7-bit status-set vector
   localparam int SET_SIE  = 0;
   localparam int SET_SPIE = 1;
   localparam int SET_SPP  = 2;
   localparam int SET_MIE  = 3;
   localparam int SET_MPIE = 4;
   localparam int SET_MPP  = 5;

   localparam logic [4:0] CAUSE_ILLEGAL_INST = 5'd2;
   localparam logic [4:0] CAUSE_ECALL_U      = 5'd8;
   localparam logic [4:0] CAUSE_ECALL_S      = 5'd9;
   localparam logic [4:0] CAUSE_ECALL_M      = 5'd11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMMIT,
      ST_REDIRECT
   } state_e;

   typedef enum logic [1:0] {
      REQ_EXC,
      REQ_MRET,
      REQ_SRET
   } req_e;

   typedef struct packed {
      req_e        kind;
      logic [4:0]  cause;
      logic [31:0] pc;
      logic [1:0]  priv;
      logic [6:0]  status;
      logic        deleg;
      logic [31:0] mtvec;
      logic [31:0] stvec;
      logic [31:0] mepc;
      logic [31:0] sepc;
      logic [31:0] mcause;
      logic [31:0] scause;
   } snap_t;

endpackage

// File: rtl/csr_trap_unit_if.sv
// Pipeline-side request and redirect bundle of the trap unit.
interface csr_trap_unit_if;
   logic        excValid_i;
   logic [4:0]  excCause_i;
   logic [31:0] instPC_i;
   logic        mretValid_i;
   logic        sretValid_i;
   logic        flush_o;
   logic        redirectValid_o;
   logic [31:0] redirectPC_o;
   logic        busy_o;

   modport master (
      output excValid_i, excCause_i, instPC_i,
      output mretValid_i, sretValid_i,
      input  flush_o, redirectValid_o, redirectPC_o, busy_o
   );

   modport slave (
      input  excValid_i, excCause_i, instPC_i,
      input  mretValid_i, sretValid_i,
      output flush_o, redirectValid_o, redirectPC_o, busy_o
   );
endinterface

// File: rtl/trap_status_calc.sv
// Delegation, new status bits, EPC/cause, privilege and target PC
// computed from the snapshot of an accepted trap or xRET.
module trap_status_calc
   import riscv_priv_pkg::*;
#(
   parameter bit SUPPORT_S = 1'b1,
   parameter bit SUPPORT_U = 1'b1
) (
   input  snap_t       snap,
   output logic [6:0]  status_set,
   output logic [31:0] mepc_set,
   output logic [31:0] mcause_set,
   output logic [31:0] sepc_set,
   output logic [31:0] scause_set,
   output logic [1:0]  priv_set,
   output logic [31:0] target_pc
);

   logic to_s;
   logic unused_bits;

   assign to_s = SUPPORT_S && (snap.priv != PRIV_M) && snap.deleg;
   assign unused_bits = ^{snap.pc[0], snap.mtvec[1:0], snap.stvec[1:0]};

   always_comb begin
      status_set = snap.status;
      mepc_set   = snap.mepc;
      mcause_set = snap.mcause;
      sepc_set   = snap.sepc;
      scause_set = snap.scause;
      priv_set   = snap.priv;
      target_pc  = '0;
      unique case (snap.kind)
         REQ_EXC: begin
            if (to_s) begin
               status_set[SET_SPP]  = snap.priv[0];
               status_set[SET_SPIE] = snap.status[SET_SIE];
               status_set[SET_SIE]  = 1'b0;
               sepc_set   = {snap.pc[31:1], 1'b0};
               scause_set = {27'b0, snap.cause};
               priv_set   = PRIV_S;
               target_pc  = {snap.stvec[31:2], 2'b00};
            end else begin
               status_set[SET_MPP+:2] = snap.priv;
               status_set[SET_MPIE]   = snap.status[SET_MIE];
               status_set[SET_MIE]    = 1'b0;
               mepc_set   = {snap.pc[31:1], 1'b0};
               mcause_set = {27'b0, snap.cause};
               priv_set   = PRIV_M;
               target_pc  = {snap.mtvec[31:2], 2'b00};
            end
         end
         REQ_MRET: begin
            priv_set             = snap.status[SET_MPP+:2];
            status_set[SET_MIE]  = snap.status[SET_MPIE];
            status_set[SET_MPIE] = 1'b1;
            status_set[SET_MPP+:2] = SUPPORT_U ? PRIV_U : PRIV_M;
            target_pc = snap.mepc;
         end
         REQ_SRET: begin
            priv_set             = {1'b0, snap.status[SET_SPP]};
            status_set[SET_SIE]  = snap.status[SET_SPIE];
            status_set[SET_SPIE] = 1'b1;
            status_set[SET_SPP]  = 1'b0;
            target_pc = snap.sepc;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/csr_trap_unit.sv
// Trap-entry / xRET sequencer: snapshot, one-cycle CSR and privilege
// commit, then PC redirect with flush.
module csr_trap_unit
   import riscv_priv_pkg::*;
#(
   parameter bit SUPPORT_S = 1'b1,
   parameter bit SUPPORT_U = 1'b1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   csr_trap_unit_if.slave pipe,
   input  logic [63:0] csrMStatus_i,
   input  logic [63:0] csrMedeleg_i,
   input  logic [31:0] csrMtvec_i,
   input  logic [31:0] csrStvec_i,
   input  logic [31:0] csrMepc_i,
   input  logic [31:0] csrSepc_i,
   input  logic [31:0] csrMCause_i,
   input  logic [31:0] csrSCause_i,
   input  logic [1:0]  privilege_i,
   output logic [6:0]  csrMStatusSet_o,
   output logic [31:0] csrMepcSet_o,
   output logic [31:0] csrMCauseSet_o,
   output logic [31:0] csrSepcSet_o,
   output logic [31:0] csrSCauseSet_o,
   output logic        csrTrapSetEn_o,
   output logic [1:0]  privilegeSet_o,
   output logic        privilegeSetEn_o
);

   state_e      state, state_n;
   snap_t       snap, snap_d;
   logic        req_any, illegal;
   req_e        kind;
   logic [4:0]  cause;
   logic [6:0]  status_set;
   logic [31:0] mepc_set, mcause_set, sepc_set, scause_set, target_pc;
   logic [1:0]  priv_set;
   logic        unused_mstatus;

   assign unused_mstatus = ^{csrMStatus_i[63:23], csrMStatus_i[21:13],
                             csrMStatus_i[10:9], csrMStatus_i[6],
                             csrMStatus_i[4], csrMStatus_i[2],
                             csrMStatus_i[0]};

   assign req_any = pipe.excValid_i | pipe.mretValid_i | pipe.sretValid_i;

   // Illegal xRETs are folded into an ordinary illegal-instruction trap
   always_comb begin
      illegal = 1'b0;
      kind    = REQ_EXC;
      cause   = pipe.excCause_i;
      if (pipe.excValid_i) begin
         kind = REQ_EXC;
      end else if (pipe.mretValid_i) begin
         kind    = REQ_MRET;
         illegal = privilege_i != PRIV_M;
      end else if (pipe.sretValid_i) begin
         kind    = REQ_SRET;
         illegal = !SUPPORT_S || privilege_i == PRIV_U ||
                   (privilege_i == PRIV_S && csrMStatus_i[MST_TSR]);
      end
      if (illegal) begin
         kind  = REQ_EXC;
         cause = CAUSE_ILLEGAL_INST;
      end
   end

   always_comb begin
      snap_d.kind   = kind;
      snap_d.cause  = cause;
      snap_d.pc     = pipe.instPC_i;
      snap_d.priv   = privilege_i;
      snap_d.status = {csrMStatus_i[MST_MPP+:2], csrMStatus_i[MST_MPIE],
                       csrMStatus_i[MST_MIE], csrMStatus_i[MST_SPP],
                       csrMStatus_i[MST_SPIE], csrMStatus_i[MST_SIE]};
      snap_d.deleg  = csrMedeleg_i[{1'b0, cause}];
      snap_d.mtvec  = csrMtvec_i;
      snap_d.stvec  = csrStvec_i;
      snap_d.mepc   = csrMepc_i;
      snap_d.sepc   = csrSepc_i;
      snap_d.mcause = csrMCause_i;
      snap_d.scause = csrSCause_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) snap <= '0;
      else if (state == ST_IDLE && req_any) snap <= snap_d;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) state <= ST_IDLE;
      else state <= state_n;
   end

   trap_status_calc #(
      .SUPPORT_S (SUPPORT_S),
      .SUPPORT_U (SUPPORT_U)
   ) u_calc (
      .snap       (snap),
      .status_set (status_set),
      .mepc_set   (mepc_set),
      .mcause_set (mcause_set),
      .sepc_set   (sepc_set),
      .scause_set (scause_set),
      .priv_set   (priv_set),
      .target_pc  (target_pc)
   );

   always_comb begin
      state_n              = state;
      csrMStatusSet_o      = '0;
      csrMepcSet_o         = '0;
      csrMCauseSet_o       = '0;
      csrSepcSet_o         = '0;
      csrSCauseSet_o       = '0;
      csrTrapSetEn_o       = 1'b0;
      privilegeSet_o       = '0;
      privilegeSetEn_o     = 1'b0;
      pipe.flush_o         = 1'b0;
      pipe.redirectValid_o = 1'b0;
      pipe.redirectPC_o    = '0;
      pipe.busy_o          = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (req_any) state_n = ST_COMMIT;
         end
         ST_COMMIT: begin
            csrMStatusSet_o  = status_set;
            csrMepcSet_o     = mepc_set;
            csrMCauseSet_o   = mcause_set;
            csrSepcSet_o     = sepc_set;
            csrSCauseSet_o   = scause_set;
            csrTrapSetEn_o   = 1'b1;
            privilegeSet_o   = priv_set;
            privilegeSetEn_o = 1'b1;
            pipe.flush_o     = 1'b1;
            pipe.busy_o      = 1'b1;
            state_n          = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            pipe.flush_o         = 1'b1;
            pipe.redirectValid_o = 1'b1;
            pipe.redirectPC_o    = target_pc;
            pipe.busy_o          = 1'b1;
            state_n              = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed-vector bench for csr_trap_unit with hand-computed results.
module tb_csr_trap_unit;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [63:0] csrMStatus_i, csrMedeleg_i;
   logic [31:0] csrMtvec_i, csrStvec_i, csrMepc_i, csrSepc_i;
   logic [31:0] csrMCause_i, csrSCause_i;
   logic [1:0]  privilege_i;
   logic [6:0]  csrMStatusSet_o;
   logic [31:0] csrMepcSet_o, csrMCauseSet_o, csrSepcSet_o, csrSCauseSet_o;
   logic        csrTrapSetEn_o, privilegeSetEn_o;
   logic [1:0]  privilegeSet_o;

   int n_cmp = 0;
   int n_err = 0;
   int busy_cnt;

   csr_trap_unit_if bus();

   always #5 clk = ~clk;

   csr_trap_unit dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .pipe             (bus.slave),
      .csrMStatus_i     (csrMStatus_i),
      .csrMedeleg_i     (csrMedeleg_i),
      .csrMtvec_i       (csrMtvec_i),
      .csrStvec_i       (csrStvec_i),
      .csrMepc_i        (csrMepc_i),
      .csrSepc_i        (csrSepc_i),
      .csrMCause_i      (csrMCause_i),
      .csrSCause_i      (csrSCause_i),
      .privilege_i      (privilege_i),
      .csrMStatusSet_o  (csrMStatusSet_o),
      .csrMepcSet_o     (csrMepcSet_o),
      .csrMCauseSet_o   (csrMCauseSet_o),
      .csrSepcSet_o     (csrSepcSet_o),
      .csrSCauseSet_o   (csrSCauseSet_o),
      .csrTrapSetEn_o   (csrTrapSetEn_o),
      .privilegeSet_o   (privilegeSet_o),
      .privilegeSetEn_o (privilegeSetEn_o)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Request is held over one edge, then dropped; DUT is then in COMMIT
   task automatic accept();
      nxt();
      bus.excValid_i  = 1'b0;
      bus.mretValid_i = 1'b0;
      bus.sretValid_i = 1'b0;
   endtask

   task automatic set_csr(input logic [63:0] mst, input logic [1:0] prv);
      csrMStatus_i = mst;
      privilege_i  = prv;
      csrMedeleg_i = '0;
      csrMtvec_i   = 32'h0000_0100;
      csrStvec_i   = 32'h8000_0101;
      csrMepc_i    = 32'hAAAA_0000;
      csrSepc_i    = 32'hBBBB_0000;
      csrMCause_i  = 32'h11;
      csrSCause_i  = 32'h22;
   endtask

   initial begin
      reset_i         = 1'b1;
      bus.excValid_i  = 1'b0;
      bus.mretValid_i = 1'b0;
      bus.sretValid_i = 1'b0;
      bus.excCause_i  = '0;
      bus.instPC_i    = '0;
      set_csr(64'h0, 2'b11);
      nxt();
      nxt();
      check("rst_trapen", csrTrapSetEn_o, 0);
      check("rst_priven", privilegeSetEn_o, 0);
      check("rst_flush", bus.flush_o, 0);
      check("rst_redir", bus.redirectValid_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_status", csrMStatusSet_o, 0);
      check("rst_priv", privilegeSet_o, 0);
      check("rst_mepc", csrMepcSet_o, 0);
      reset_i = 1'b0;
      nxt();

      // ECALL from U delegated to S
      set_csr(64'h2, 2'b00);
      csrMedeleg_i   = 64'h100;
      bus.excValid_i = 1'b1;
      bus.excCause_i = 5'd8;
      bus.instPC_i   = 32'h0000_1234;
      accept();
      check("s_trapen", csrTrapSetEn_o, 1);
      check("s_priven", privilegeSetEn_o, 1);
      check("s_flush", bus.flush_o, 1);
      check("s_busy", bus.busy_o, 1);
      check("s_status", csrMStatusSet_o, 7'b0000010);
      check("s_sepc", csrSepcSet_o, 32'h1234);
      check("s_scause", csrSCauseSet_o, 8);
      check("s_mepc", csrMepcSet_o, 32'hAAAA_0000);
      check("s_mcause", csrMCauseSet_o, 32'h11);
      check("s_priv", privilegeSet_o, 2'b01);
      check("s_redir0", bus.redirectValid_o, 0);
      nxt();
      check("s_redir", bus.redirectValid_o, 1);
      check("s_rpc", bus.redirectPC_o, 32'h8000_0100);
      check("s_flush2", bus.flush_o, 1);
      check("s_trapen2", csrTrapSetEn_o, 0);
      nxt();
      check("s_idle", bus.busy_o, 0);

      // Same ECALL, no delegation: trap to M; mtvec change after accept ignored
      set_csr(64'h8, 2'b00);
      bus.excValid_i = 1'b1;
      bus.excCause_i = 5'd8;
      bus.instPC_i   = 32'h0000_1234;
      accept();
      csrMtvec_i = 32'h0000_FFF0;
      check("m_status", csrMStatusSet_o, 7'b0010000);
      check("m_mepc", csrMepcSet_o, 32'h1234);
      check("m_mcause", csrMCauseSet_o, 8);
      check("m_sepc", csrSepcSet_o, 32'hBBBB_0000);
      check("m_scause", csrSCauseSet_o, 32'h22);
      check("m_priv", privilegeSet_o, 2'b11);
      nxt();
      check("m_rpc", bus.redirectPC_o, 32'h100);
      nxt();

      // MRET from M with MPP=S, MPIE=1
      set_csr(64'h880, 2'b11);
      csrMepc_i       = 32'h2000;
      bus.mretValid_i = 1'b1;
      accept();
      check("mret_priv", privilegeSet_o, 2'b01);
      check("mret_status", csrMStatusSet_o, 7'b0011000);
      check("mret_mepc", csrMepcSet_o, 32'h2000);
      check("mret_mcause", csrMCauseSet_o, 32'h11);
      check("mret_trapen", csrTrapSetEn_o, 1);
      nxt();
      check("mret_rpc", bus.redirectPC_o, 32'h2000);
      nxt();

      // MRET from S is illegal
      set_csr(64'h0, 2'b01);
      csrMtvec_i      = 32'h200;
      bus.instPC_i    = 32'h40;
      bus.mretValid_i = 1'b1;
      accept();
      check("ilm_mcause", csrMCauseSet_o, 2);
      check("ilm_mepc", csrMepcSet_o, 32'h40);
      check("ilm_priv", privilegeSet_o, 2'b11);
      check("ilm_status", csrMStatusSet_o, 7'b0100000);
      nxt();
      check("ilm_rpc", bus.redirectPC_o, 32'h200);
      nxt();

      // SRET from S with TSR set is illegal
      set_csr(64'h40_0000, 2'b01);
      csrMtvec_i      = 32'h200;
      bus.instPC_i    = 32'h44;
      bus.sretValid_i = 1'b1;
      accept();
      check("ils_mcause", csrMCauseSet_o, 2);
      check("ils_mepc", csrMepcSet_o, 32'h44);
      check("ils_priv", privilegeSet_o, 2'b11);
      nxt();
      check("ils_rpc", bus.redirectPC_o, 32'h200);
      nxt();

      // Legal SRET from S with SPP=1, SPIE=1
      set_csr(64'h120, 2'b01);
      csrSepc_i       = 32'h3000;
      bus.sretValid_i = 1'b1;
      accept();
      check("sret_priv", privilegeSet_o, 2'b01);
      check("sret_status", csrMStatusSet_o, 7'b0000011);
      check("sret_sepc", csrSepcSet_o, 32'h3000);
      nxt();
      check("sret_rpc", bus.redirectPC_o, 32'h3000);
      nxt();

      // Exception beats MRET; a new exception during COMMIT is ignored
      set_csr(64'h0, 2'b11);
      bus.excValid_i  = 1'b1;
      bus.mretValid_i = 1'b1;
      bus.excCause_i  = 5'd11;
      bus.instPC_i    = 32'h500;
      busy_cnt = 0;
      nxt();
      bus.mretValid_i = 1'b0;
      bus.excCause_i  = 5'd3;
      bus.instPC_i    = 32'h900;
      if (bus.busy_o) busy_cnt++;
      check("pri_mcause", csrMCauseSet_o, 11);
      check("pri_mepc", csrMepcSet_o, 32'h500);
      nxt();
      if (bus.busy_o) busy_cnt++;
      check("pri_rpc", bus.redirectPC_o, 32'h100);
      bus.excValid_i = 1'b0;
      nxt();
      if (bus.busy_o) busy_cnt++;
      check("pri_noacc", csrTrapSetEn_o, 0);
      nxt();
      if (bus.busy_o) busy_cnt++;
      check("pri_busy2", busy_cnt, 2);

      // Reset during COMMIT cancels the operation
      set_csr(64'h0, 2'b11);
      bus.excValid_i = 1'b1;
      bus.excCause_i = 5'd11;
      accept();
      check("rm_commit", csrTrapSetEn_o, 1);
      reset_i = 1'b1;
      nxt();
      check("rm_trapen", csrTrapSetEn_o, 0);
      check("rm_priven", privilegeSetEn_o, 0);
      check("rm_redir", bus.redirectValid_o, 0);
      check("rm_busy", bus.busy_o, 0);
      reset_i = 1'b0;
      nxt();
      check("rm_noredir", bus.redirectValid_o, 0);
      check("rm_flush", bus.flush_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
